// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SDRAM arbiter (mem_arbiter, mem_arb_rfsh).
package mem_arb_pkg;

    // Arbiter transaction states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Source-select codes, listed in arbitration priority order
    typedef enum logic [1:0] {
        SRC_RF  = 2'd0,
        SRC_INI = 2'd1,
        SRC_DL  = 2'd2,
        SRC_CPU = 2'd3
    } src_t;

    // First page of the I/O window; pages between the ROM top and here are unmapped
    localparam logic [7:0] PAGE_UNMAPPED = 8'hC0;

    // CPU byte address space is 4 MB; SDRAM address space is 16 MB
    function automatic logic [23:0] cpu_to_sdr(input logic [21:0] a);
        return {2'b00, a};
    endfunction

    // 16 KB page number of a CPU address
    function automatic logic [7:0] cpu_page(input logic [21:0] a);
        return a[21:14];
    endfunction

endpackage

// File: rtl/mem_arb_rfsh.sv
// Refresh bookkeeping: pending flag and starvation counter for mem_arbiter.
module mem_arb_rfsh
    import mem_arb_pkg::*;
#(
    parameter int RFSH_MAX = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic rfReq,
    input  logic rfIssue,
    output logic rfPend,
    output logic rfUrgent
);

    localparam int CW = $clog2(RFSH_MAX + 1);

    logic          r_pend;
    logic [CW-1:0] r_cnt;

    // Track an outstanding refresh and how long it has been waiting; issue wins over a new request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend <= 1'b0;
            r_cnt  <= '0;
        end else if (rfIssue) begin
            r_pend <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (rfReq) begin
                r_pend <= 1'b1;
            end
            if (r_pend && (r_cnt != CW'(RFSH_MAX))) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign rfPend   = r_pend;
    assign rfUrgent = r_pend && (r_cnt == CW'(RFSH_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// SDRAM arbiter: refresh > init loader > download > CPU, one SDRAM cycle at a time.
// Optional ROM write protection is enabled by defining MEM_ARB_ROMWP_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int         RFSH_MAX = 64,
    parameter int         TMO      = 255,
    parameter logic [7:0] ROMPG    = 8'd7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rfReq,
    input  logic        iniReq,
    input  logic [23:0] iniA,
    input  logic [7:0]  iniD,
    output logic        iniAck,
    input  logic        dlReq,
    input  logic [23:0] dlA,
    input  logic [7:0]  dlD,
    output logic        dlAck,
    input  logic        cpuRd,
    input  logic        cpuWr,
    input  logic [21:0] cpuA,
    input  logic [7:0]  cpuD,
    output logic [7:0]  cpuQ,
    output logic        cpuAck,
    input  logic [7:0]  romP,
    output logic        sdrRf,
    output logic        sdrRd,
    output logic        sdrWr,
    output logic [23:0] sdrA,
    output logic [15:0] sdrD,
    input  logic [15:0] sdrQ,
    input  logic        sdrAck,
    input  logic        sdrReady,
    output logic        err
);

    localparam int TW = $clog2(TMO + 1);

    state_t        r_state;
    src_t          r_src;
    logic          r_isRd;
    logic [TW-1:0] r_tmo;
    logic          r_err;
    logic          r_cpuHold;
    logic          r_sdrRf;
    logic          r_sdrRd;
    logic          r_sdrWr;
    logic [23:0]   r_sdrA;
    logic [15:0]   r_sdrD;
    logic [7:0]    r_cpuQ;
    logic          r_iniAck;
    logic          r_dlAck;
    logic          r_cpuAck;

    logic          w_rfPend;
    logic          w_rfUrgent;
    logic          w_rfWin;
    logic          w_rfIssue;
    logic          w_cpuReq;
    logic [7:0]    w_page;
    logic [7:0]    w_romTop;
    logic          w_unmapRd;
    logic          w_wrProt;
    logic          w_unused;

    mem_arb_rfsh #(
        .RFSH_MAX (RFSH_MAX)
    ) u_rfsh (
        .clock    (clock),
        .reset    (reset),
        .rfReq    (rfReq),
        .rfIssue  (w_rfIssue),
        .rfPend   (w_rfPend),
        .rfUrgent (w_rfUrgent)
    );

    // A refresh arriving this very cycle already outranks everything, so it is
    // folded into the win term rather than waiting a cycle for rfPend.
    assign w_rfWin   = w_rfPend | w_rfUrgent | rfReq;
    assign w_rfIssue = (r_state == ST_IDLE) && sdrReady && w_rfWin;

    // The CPU is blocked after an ack until both strobes have been seen low.
    assign w_cpuReq  = (cpuRd | cpuWr) & ~r_cpuHold;
    assign w_page    = cpu_page(cpuA);

    // A romP pointing into the I/O window is not a sensible ROM top; fall back to ROMPG.
    assign w_romTop  = (romP >= PAGE_UNMAPPED) ? ROMPG : romP;
    assign w_unmapRd = cpuRd && (w_page > w_romTop) && (w_page < PAGE_UNMAPPED);

`ifdef MEM_ARB_ROMWP_EN
    // ROM pages are read-only, except the upper half of page 7 (writable scratch area).
    assign w_wrProt  = cpuWr && !cpuRd && (w_page <= w_romTop) &&
                       !((w_page == 8'h07) && cpuA[13]);
`else
    assign w_wrProt  = 1'b0;
`endif

    // Only the low byte of the SDRAM word carries CPU data.
    assign w_unused  = &{1'b0, sdrQ[15:8]};

    // Main arbitration FSM with registered SDRAM strobes, address/data and acks
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_src     <= SRC_RF;
            r_isRd    <= 1'b0;
            r_tmo     <= '0;
            r_err     <= 1'b0;
            r_cpuHold <= 1'b0;
            r_sdrRf   <= 1'b0;
            r_sdrRd   <= 1'b0;
            r_sdrWr   <= 1'b0;
            r_sdrA    <= '0;
            r_sdrD    <= '0;
            r_cpuQ    <= 8'hFF;
            r_iniAck  <= 1'b0;
            r_dlAck   <= 1'b0;
            r_cpuAck  <= 1'b0;
        end else begin
            r_sdrRf  <= 1'b0;
            r_sdrRd  <= 1'b0;
            r_sdrWr  <= 1'b0;
            r_iniAck <= 1'b0;
            r_dlAck  <= 1'b0;
            r_cpuAck <= 1'b0;

            // Back in IDLE with the ack already past: strobes low releases the CPU
            if ((r_state == ST_IDLE) && !r_cpuAck && !cpuRd && !cpuWr) begin
                r_cpuHold <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (sdrReady) begin
                        if (w_rfWin) begin
                            r_src   <= SRC_RF;
                            r_isRd  <= 1'b0;
                            r_sdrRf <= 1'b1;
                            r_sdrA  <= '0;
                            r_sdrD  <= '0;
                            r_state <= ST_ISSUE;
                        end else if (iniReq) begin
                            r_src   <= SRC_INI;
                            r_isRd  <= 1'b0;
                            r_sdrWr <= 1'b1;
                            r_sdrA  <= iniA;
                            r_sdrD  <= {8'd0, iniD};
                            r_state <= ST_ISSUE;
                        end else if (dlReq) begin
                            r_src   <= SRC_DL;
                            r_isRd  <= 1'b0;
                            r_sdrWr <= 1'b1;
                            r_sdrA  <= dlA;
                            r_sdrD  <= {8'd0, dlD};
                            r_state <= ST_ISSUE;
                        end else if (w_cpuReq) begin
                            r_cpuHold <= 1'b1;
                            if (w_unmapRd || w_wrProt) begin
                                // Answered locally, no SDRAM cycle
                                r_cpuAck <= 1'b1;
                                if (w_unmapRd) begin
                                    r_cpuQ <= 8'hFF;
                                end
                            end else begin
                                r_src   <= SRC_CPU;
                                r_isRd  <= cpuRd;
                                r_sdrRd <= cpuRd;
                                r_sdrWr <= !cpuRd;
                                r_sdrA  <= cpu_to_sdr(cpuA);
                                r_sdrD  <= {8'd0, cpuD};
                                r_state <= ST_ISSUE;
                            end
                        end
                    end
                end

                ST_ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (sdrAck) begin
                        if (r_isRd) begin
                            r_cpuQ <= sdrQ[7:0];
                        end
                        r_state <= ST_DONE;
                    end else if (r_tmo == TW'(TMO - 1)) begin
                        r_err <= 1'b1;
                        if (r_isRd) begin
                            r_cpuQ <= 8'hFF;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                ST_DONE: begin
                    case (r_src)
                        SRC_INI: r_iniAck <= 1'b1;
                        SRC_DL:  r_dlAck  <= 1'b1;
                        SRC_CPU: r_cpuAck <= 1'b1;
                        default: ;
                    endcase
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sdrRf  = r_sdrRf;
    assign sdrRd  = r_sdrRd;
    assign sdrWr  = r_sdrWr;
    assign sdrA   = r_sdrA;
    assign sdrD   = r_sdrD;
    assign cpuQ   = r_cpuQ;
    assign iniAck = r_iniAck;
    assign dlAck  = r_dlAck;
    assign cpuAck = r_cpuAck;
    assign err    = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected SDRAM commands and acks are queued
// at stimulus time and popped by a monitor sampling on the falling clock edge.
module tb_mem_arbiter;

    localparam int RFSH_MAX = 64;
    localparam int TMO      = 255;
    localparam logic [1:0] K_RF = 2'd0, K_RD = 2'd1, K_WR = 2'd2;

    typedef struct { logic [1:0] kind; logic [23:0] a; logic [15:0] d; } cmd_t;
    typedef struct { bit chk_q; logic [7:0] q; } ack_t;

    logic clock = 1'b0, reset = 1'b0;
    logic rfReq = 0, iniReq = 0, dlReq = 0, cpuRd = 0, cpuWr = 0;
    logic [23:0] iniA = 0, dlA = 0;
    logic [7:0]  iniD = 0, dlD = 0, cpuD = 0, romP = 8'd7;
    logic [21:0] cpuA = 0;
    logic [15:0] sdrQ;
    logic        sdrAck, sdrReady = 1'b0;
    logic        iniAck, dlAck, cpuAck, sdrRf, sdrRd, sdrWr, err;
    logic [7:0]  cpuQ;
    logic [23:0] sdrA;
    logic [15:0] sdrD;

    int errors = 0, checks = 0, cyc = 0;
    int n_cmd = 0, cpu_ack_cnt = 0, last_rf_cyc = -1;
    bit sdr_mute = 0;
    int sdr_dly_max = 0;

    cmd_t exp_cmd[$];
    ack_t exp_cpu[$];
    int   exp_ini[$];
    int   exp_dl[$];

    mem_arbiter #(.RFSH_MAX(RFSH_MAX), .TMO(TMO), .ROMPG(8'd7)) dut (
        .clock(clock), .reset(reset), .rfReq(rfReq),
        .iniReq(iniReq), .iniA(iniA), .iniD(iniD), .iniAck(iniAck),
        .dlReq(dlReq), .dlA(dlA), .dlD(dlD), .dlAck(dlAck),
        .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD),
        .cpuQ(cpuQ), .cpuAck(cpuAck), .romP(romP),
        .sdrRf(sdrRf), .sdrRd(sdrRd), .sdrWr(sdrWr), .sdrA(sdrA), .sdrD(sdrD),
        .sdrQ(sdrQ), .sdrAck(sdrAck), .sdrReady(sdrReady), .err(err)
    );

    initial forever #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog actual=time_expired required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Data the SDRAM stub returns for an address
    function automatic logic [15:0] sdrq_of(input logic [23:0] a);
        if (a == 24'h001234) return 16'h00A5;
        return {a[23:16] ^ 8'h77, a[7:0] ^ a[15:8] ^ 8'h3C};
    endfunction

    // Reference rules for CPU accesses
    function automatic bit m_unmapped(input logic [7:0] pg, input logic [7:0] rp);
        return (pg > rp) && (pg < 8'hC0);
    endfunction

    function automatic bit m_protected(input logic [21:0] a, input logic [7:0] rp);
        logic [7:0] pg;
        pg = a[21:14];
`ifdef MEM_ARB_ROMWP_EN
        if ((pg == 8'h07) && a[13]) return 1'b0;
        return pg <= rp;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_cmd(input logic [1:0] k, input logic [23:0] a, input logic [15:0] d);
        cmd_t c;
        c.kind = k; c.a = a; c.d = d;
        exp_cmd.push_back(c);
    endtask

    task automatic push_cpu(input bit chk, input logic [7:0] q);
        ack_t e;
        e.chk_q = chk; e.q = q;
        exp_cpu.push_back(e);
    endtask

    // SDRAM stub: acks each command after 1+random cycles unless muted
    initial begin
        logic [23:0] a;
        int d;
        sdrAck = 1'b0;
        sdrQ   = 16'h0;
        forever begin
            @(posedge clock); #1;
            if ((sdrRf | sdrRd | sdrWr) && !sdr_mute) begin
                a = sdrA;
                d = $urandom_range(0, sdr_dly_max);
                repeat (d + 1) @(posedge clock);
                #1;
                sdrQ = sdrq_of(a);
                sdrAck = 1'b1;
                @(posedge clock); #1;
                sdrAck = 1'b0;
                sdrQ = 16'($urandom);
            end
        end
    end

    // Monitor: every strobe or ack must match the head of its expectation queue
    initial begin
        cmd_t e;
        ack_t ea;
        logic [1:0] k;
        forever begin
            @(negedge clock);
            if (sdrRf | sdrRd | sdrWr) begin
                n_cmd++;
                if (sdrRf) last_rf_cyc = cyc;
                k = sdrRf ? K_RF : (sdrRd ? K_RD : K_WR);
                check($countones({sdrRf, sdrRd, sdrWr}) == 1, "strobe_onehot",
                      {29'd0, sdrRf, sdrRd, sdrWr}, 32'd1);
                if (exp_cmd.size() == 0) begin
                    check(1'b0, "unexpected_cmd", {30'd0, k}, 32'hFFFF);
                end else begin
                    e = exp_cmd.pop_front();
                    check(k == e.kind, "cmd_kind", {30'd0, k}, {30'd0, e.kind});
                    if (e.kind != K_RF) begin
                        check(sdrA == e.a, "cmd_addr", {8'd0, sdrA}, {8'd0, e.a});
                        check(sdrD == e.d, "cmd_data", {16'd0, sdrD}, {16'd0, e.d});
                    end
                end
            end
            if (cpuAck) begin
                cpu_ack_cnt++;
                if (exp_cpu.size() == 0) begin
                    check(1'b0, "unexpected_cpuAck", 32'd1, 32'd0);
                end else begin
                    ea = exp_cpu.pop_front();
                    if (ea.chk_q) check(cpuQ == ea.q, "cpuQ", {24'd0, cpuQ}, {24'd0, ea.q});
                    else          check(1'b1, "cpuAck_wr", 32'd1, 32'd1);
                end
            end
            if (iniAck) begin
                check(exp_ini.size() != 0, "iniAck_expected", 32'd1, exp_ini.size());
                if (exp_ini.size() != 0) void'(exp_ini.pop_front());
            end
            if (dlAck) begin
                check(exp_dl.size() != 0, "dlAck_expected", 32'd1, exp_dl.size());
                if (exp_dl.size() != 0) void'(exp_dl.pop_front());
            end
        end
    end

    // Queue expectations for a set of simultaneous requests, drive them, and
    // drop each request when its ack appears. lat = cycles from request to cpuAck.
    task automatic run_txn(input bit rf, input bit ini, input bit dl, input bit cpu, input bit rd,
                           input logic [21:0] ca, input logic [7:0] cd,
                           input logic [23:0] ia, input logic [7:0] idt,
                           input logic [23:0] da, input logic [7:0] ddt, output int lat);
        int start, n;
        bit pi, pd, pc;
        logic [23:0] sa;
        lat = -1;
        if (rf) push_cmd(K_RF, 24'd0, 16'd0);
        if (ini) begin push_cmd(K_WR, ia, {8'd0, idt}); exp_ini.push_back(1); end
        if (dl)  begin push_cmd(K_WR, da, {8'd0, ddt}); exp_dl.push_back(1); end
        if (cpu) begin
            sa = {2'b00, ca};
            if (rd && m_unmapped(ca[21:14], romP)) push_cpu(1'b1, 8'hFF);
            else if (!rd && m_protected(ca, romP)) push_cpu(1'b0, 8'h00);
            else begin
                push_cmd(rd ? K_RD : K_WR, sa, {8'd0, cd});
                push_cpu(rd, sdr_mute ? 8'hFF : sdrq_of(sa)[7:0]);
            end
        end
        iniA = ia; iniD = idt; dlA = da; dlD = ddt; cpuA = ca; cpuD = cd;
        rfReq = rf; iniReq = ini; dlReq = dl; cpuRd = cpu & rd; cpuWr = cpu & ~rd;
        pi = ini; pd = dl; pc = cpu;
        start = cyc;
        n = 0;
        while ((pi || pd || pc) && (n < 2000)) begin
            @(posedge clock); #1;
            n++;
            rfReq = 1'b0;
            if (iniAck) begin iniReq = 1'b0; pi = 0; end
            if (dlAck)  begin dlReq = 1'b0; pd = 0; end
            if (cpuAck) begin cpuRd = 1'b0; cpuWr = 1'b0; pc = 0; lat = cyc - start; end
        end
        check(n < 2000, "txn_timeout", n, 2000);
        iniReq = 0; dlReq = 0; cpuRd = 0; cpuWr = 0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        int lat, cnt0, rf_cyc, nack, n;
        bit rf, ini, dl, cpu, rd;
        logic [7:0] pg;
        logic [21:0] ca;

        // Reset values while reset is held low
        #12;
        check(cpuQ == 8'hFF, "rst_cpuQ", cpuQ, 8'hFF);
        check({sdrRf, sdrRd, sdrWr, iniAck, dlAck, cpuAck, err} == 7'd0, "rst_ctrl",
              {sdrRf, sdrRd, sdrWr, iniAck, dlAck, cpuAck, err}, 0);
        check({sdrA, sdrD} == 40'd0, "rst_addr_data", sdrA, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // No arbitration while the SDRAM is not ready
        cpuRd = 1'b1; cpuA = 22'h000010;
        repeat (6) @(posedge clock);
        #1;
        check((n_cmd == 0) && (cpu_ack_cnt == 0), "not_ready_idle", n_cmd + cpu_ack_cnt, 0);
        cpuRd = 1'b0;
        sdrReady = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Single CPU read
        sdr_dly_max = 0;
        run_txn(0, 0, 0, 1, 1, 22'h001234, 8'h00, 0, 0, 0, 0, lat);
        check(lat == 4, "rd_latency", lat, 4);
        check(cpuQ == 8'hA5, "rd_cpuQ_held", cpuQ, 8'hA5);

        // Refresh and CPU write in the same cycle
        cnt0 = cpu_ack_cnt;
        run_txn(1, 0, 0, 1, 0, 22'h000456, 8'h3C, 0, 0, 0, 0, lat);
        check(cpu_ack_cnt - cnt0 == 1, "rf_cpuwr_ack_once", cpu_ack_cnt - cnt0, 1);

        // ROM write protection and unmapped reads, romP = 7
        romP = 8'd7;
        ca = {8'd3, 14'h0100};
        run_txn(0, 0, 0, 1, 0, ca, 8'h11, 0, 0, 0, 0, lat);
        check(lat == (m_protected(ca, romP) ? 1 : 4), "wp_page3_latency", lat, m_protected(ca, romP) ? 1 : 4);
        ca = {8'd7, 1'b1, 13'h0042};
        run_txn(0, 0, 0, 1, 0, ca, 8'h22, 0, 0, 0, 0, lat);
        check(lat == 4, "wp_page7_hi_latency", lat, 4);
        run_txn(0, 0, 0, 1, 1, {8'h20, 14'h0005}, 8'h00, 0, 0, 0, 0, lat);
        check(lat == 1, "unmapped_rd_latency", lat, 1);

        // Init and download together: init first
        run_txn(0, 1, 1, 0, 0, 0, 0, 24'hABCDEF, 8'h5A, 24'h123456, 8'hC3, lat);

        // Refresh starvation with download held continuously
        push_cmd(K_WR, 24'h0F0F00, 16'h0077);
        exp_dl.push_back(1);
        dlA = 24'h0F0F00; dlD = 8'h77; dlReq = 1'b1;
        n = 0;
        while (!sdrWr && n < 50) begin @(posedge clock); #1; n++; end
        check(n < 50, "starve_dl_start", n, 50);
        rfReq = 1'b1; rf_cyc = cyc;
        push_cmd(K_RF, 0, 0);
        push_cmd(K_WR, 24'h0F0F00, 16'h0077);
        push_cmd(K_WR, 24'h0F0F00, 16'h0077);
        exp_dl.push_back(1); exp_dl.push_back(1);
        nack = 0; n = 0;
        while (nack < 3 && n < 500) begin
            @(posedge clock); #1;
            n++;
            rfReq = 1'b0;
            if (dlAck) nack++;
        end
        dlReq = 1'b0;
        check(n < 500, "starve_dl_done", n, 500);
        check((last_rf_cyc > rf_cyc) && (last_rf_cyc - rf_cyc <= RFSH_MAX + 4), "rf_starve_latency",
              last_rf_cyc - rf_cyc, RFSH_MAX + 4);
        repeat (3) @(posedge clock);
        #1;

        // Randomised mix of sources, page classes and concurrent refresh
        sdr_dly_max = 2;
        for (int i = 0; i < 40; i++) begin
            romP = 8'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0:       pg = 8'($urandom_range(0, romP));
                1:       pg = 8'($urandom_range(romP + 1, 8'hBF));
                default: pg = 8'($urandom_range(8'hC0, 8'hFF));
            endcase
            rf  = ($urandom_range(0, 3) == 0);
            ini = ($urandom_range(0, 3) == 0);
            dl  = ($urandom_range(0, 3) == 0);
            cpu = ($urandom_range(0, 1) == 1) || !(ini || dl);
            rd  = $urandom_range(0, 1);
            run_txn(rf, ini, dl, cpu, rd, {pg, 14'($urandom)}, 8'($urandom),
                    24'($urandom), 8'($urandom), 24'($urandom), 8'($urandom), lat);
        end
        check(err == 1'b0, "err_clear_normal", err, 0);

        // Timeout: SDRAM never acks
        sdr_dly_max = 0;
        romP = 8'd7;
        sdr_mute = 1;
        run_txn(0, 0, 0, 1, 1, 22'h004321, 8'h00, 0, 0, 0, 0, lat);
        check(lat == TMO + 3, "timeout_latency", lat, TMO + 3);
        check(err == 1'b1, "timeout_err", err, 1);
        check(cpuQ == 8'hFF, "timeout_cpuQ", cpuQ, 8'hFF);

        // Reset while waiting for the SDRAM
        push_cmd(K_RD, 24'h000777, 16'h0000);
        cnt0 = cpu_ack_cnt;
        cpuA = 22'h000777; cpuD = 8'h00; cpuRd = 1'b1;
        n = 0;
        while (!sdrRd && n < 20) begin @(posedge clock); #1; n++; end
        check(n < 20, "rst_rd_issue", n, 20);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check({sdrRf, sdrRd, sdrWr, iniAck, dlAck, cpuAck} == 6'd0, "rst_mid_strobes",
              {sdrRf, sdrRd, sdrWr, iniAck, dlAck, cpuAck}, 0);
        check((cpuQ == 8'hFF) && (err == 1'b0), "rst_mid_cpuQ_err", {cpuQ, 7'd0, err}, 32'hFF00);
        cpuRd = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check(cpu_ack_cnt == cnt0, "rst_no_ack", cpu_ack_cnt - cnt0, 0);
        sdr_mute = 0;
        run_txn(0, 0, 0, 1, 1, 22'h001234, 8'h00, 0, 0, 0, 0, lat);
        check(lat == 4, "post_rst_rd_latency", lat, 4);

        repeat (5) @(posedge clock);
        #1;
        check(exp_cmd.size() == 0, "cmd_queue_empty", exp_cmd.size(), 0);
        check(exp_cpu.size() + exp_ini.size() + exp_dl.size() == 0, "ack_queues_empty",
              exp_cpu.size() + exp_ini.size() + exp_dl.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: RFSH_MAX = 64, refresh starvation limit in cycles; TMO = 255, SDRAM ack timeout in cycles; ROMPG = 8'd7, default highest ROM page.
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1: single clock; all logic is on its rising edge.
- reset, in, 1: asynchronous, active-low.
- rfReq, in, 1: refresh request pulse.
- iniReq, in, 1: init-loader write request; iniA [23:0], iniD [7:0]; iniAck, out, 1.
- dlReq, in, 1: download write request; dlA [23:0], dlD [7:0]; dlAck, out, 1.
- cpuRd, in, 1 and cpuWr, in, 1: CPU access strobes; cpuA [21:0], cpuD [7:0].
- cpuQ, out, 8: CPU read data; cpuAck, out, 1.
- romP, in, 8: highest ROM page.
- sdrRf, sdrRd, sdrWr, out, 1 each: SDRAM command strobes.
- sdrA, out, 24 and sdrD, out, 16: SDRAM address and write data.
- sdrQ, in, 16: SDRAM read data; sdrAck, in, 1: cycle-complete pulse.
- sdrReady, in, 1: SDRAM initialised.
- err, out, 1: sticky timeout flag.

Function
REQ-003 States: IDLE, ISSUE, WAIT, DONE. Encoding is free; exactly one state is active at a time.
REQ-004 IDLE: remain in IDLE while sdrReady=0. Otherwise pick the highest pending source in this order: refresh, init, download, CPU. Latch the winner's address, data and type, then go to ISSUE.
REQ-005 Refresh: rfReq sets rfPend. rfPend clears when the refresh cycle is issued. A second rfReq while rfPend=1 is absorbed.
REQ-006 Starvation: while rfPend=1, a counter increments each cycle. At RFSH_MAX, refresh wins the next IDLE arbitration regardless of order. The counter clears on issue.
REQ-007 ISSUE lasts one cycle:
- Asserts exactly one of sdrRf, sdrRd, sdrWr.
- sdrA = latched address; CPU addresses are zero-extended by 2 bits.
- sdrD = {8'd0, data}.
- Then go to WAIT.
REQ-008 WAIT: on sdrAck go to DONE; for reads, capture sdrQ[7:0] into cpuQ in the same cycle.
REQ-009 If TMO cycles elapse in WAIT without sdrAck: set err and go to DONE. A CPU read that timed out returns cpuQ = 8'hFF.
REQ-010 DONE lasts one cycle: pulse the winner's ack for exactly one cycle (no ack for refresh), then return to IDLE. Minimum request-to-ack latency is 4 cycles.
REQ-011 CPU strobes are level requests. A CPU request is not re-arbitrated until cpuRd and cpuWr have both been low for at least one cycle after cpuAck.
REQ-012 CPU reads of page cpuA[21:14] > romP and < 8'hC0 (unmapped) are acked from IDLE in 1 cycle with cpuQ = 8'hFF and no SDRAM cycle.
REQ-013 A request and rfReq arriving in the same cycle: the request is not lost and is served after the refresh.
REQ-014 Requester inputs change only while the winner is in IDLE; the arbiter holds its latched copies until DONE.
REQ-015 iniReq and dlReq both high at the same time: init is served first, and download waits.

Reset
REQ-016 On reset low, all of the following are forced immediately (asynchronously):
- state = IDLE.
- sdrRf, sdrRd, sdrWr, iniAck, dlAck, cpuAck = 0.
- cpuQ = 8'hFF.
- sdrA, sdrD = 0.
- rfPend, starvation counter, timeout counter, err = 0.
REQ-017 Reset asserted mid-cycle abandons the transaction with no ack. After release the block restarts in IDLE.

Configuration
REQ-018 Macro MEM_ARB_ROMWP_EN controls ROM write protection.
- Defined: CPU writes to pages <= romP are acked in 1 cycle with no SDRAM cycle. Exception: page 8'h07 with cpuA[13]=1 is writable.
- Undefined: all CPU writes go to SDRAM. Download and init writes are never protected.

Structure
REQ-019 A shared package mem_arb_pkg holds:
- the state enum,
- source-select codes (RF, INI, DL, CPU),
- constant PAGE_UNMAPPED = 8'hC0.
REQ-020 One sub-module, mem_arb_rfsh, contains rfPend and the starvation counter and outputs rfUrgent. All other logic is in mem_arbiter.

Verification
REQ-021 Bench scenarios:
- Single CPU read: cpuRd=1, cpuA=22'h001234, sdrQ=16'h00A5 at sdrAck -> sdrRd one cycle, sdrA=24'h001234, cpuAck 4 cycles after request, cpuQ=8'hA5.
- Simultaneous rfReq and cpuWr -> sdrRf issued first; cpuWr served next; cpuAck exactly once.
- Refresh starvation: rfReq pending while dlReq is held continuously -> refresh issued no later than RFSH_MAX+4 cycles after rfReq.
- Timeout: cpuRd with sdrAck never asserted -> err=1 after TMO cycles in WAIT, cpuAck pulse, cpuQ=8'hFF.
- MEM_ARB_ROMWP_EN defined, romP=7: cpuWr to page 3 -> cpuAck with no sdrWr; cpuWr to page 7 with cpuA[13]=1 -> sdrWr issued.
- Reset asserted in WAIT -> all strobes 0 immediately, no ack; after release, a CPU read completes normally.
